// File: rtl/fixed_sat_mult_pipe.sv
// fixed_sat_mult_pipe: two-stage pipelined signed fixed-point multiplier.
// Stage 1 registers the full-width product. Stage 2 rounds it, shifts it into
// the output Q format and saturates it, raising a per-sample overflow or
// underflow flag. Both sides use valid/ready, and a stall holds each stage's
// data unchanged. A saturating counter tallies delivered saturated results.
module fixed_sat_mult_pipe #(
  parameter int IN_W     = 32,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             round_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] p_out,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             cnt_clr
);

  localparam int SHIFT = 2 * IN_FRAC - OUT_FRAC;
  localparam int PW    = 2 * IN_W;
  // One extra bit so that adding the rounding constant can never wrap.
  localparam int EW    = PW + 1;

  localparam logic signed [EW-1:0] SAT_MAX  = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN  = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [EW-1:0] HALF_LSB = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  // Refuse to elaborate when there is nothing to shift away or the output
  // would be wider than the product.
  if (SHIFT < 1 || OUT_W > PW) begin : g_bad_params
    $error("fixed_sat_mult_pipe: illegal parameters (need SHIFT >= 1 and OUT_W <= 2*IN_W)");
  end

  logic          advance1;
  logic          advance2;
  logic          s1_valid;
  logic          s1_round;
  logic [PW-1:0] s1_prod;
  logic          s2_valid;
  logic [PW-1:0] prod_c;

  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] shifted;
  logic [OUT_W-1:0]     p_next;
  logic                 ovf_next;
  logic                 unf_next;

  // Each stage moves when its successor has room. in_ready therefore depends
  // combinationally on out_ready, since there is no skid buffer.
  assign advance2  = !s2_valid || out_ready;
  assign advance1  = !s1_valid || advance2;
  assign in_ready  = advance1;
  assign out_valid = s2_valid;

  // Sign-extend both operands to product width. The low PW bits of this
  // unsigned multiply form the exact two's-complement product.
  assign prod_c = {{IN_W{a_in[IN_W-1]}}, a_in} * {{IN_W{b_in[IN_W-1]}}, b_in};

  // Round half up (optional), shift arithmetically into the output Q format, then clamp.
  always_comb begin
    rounded  = $signed({s1_prod[PW-1], s1_prod}) + (s1_round ? HALF_LSB : '0);
    shifted  = rounded >>> SHIFT;
    p_next   = shifted[OUT_W-1:0];
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (shifted > SAT_MAX) begin
      p_next   = SAT_MAX[OUT_W-1:0];
      ovf_next = 1'b1;
    end else if (shifted < SAT_MIN) begin
      p_next   = SAT_MIN[OUT_W-1:0];
      unf_next = 1'b1;
    end
  end

  // Stage 1 captures the raw product and rounding mode on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_round <= 1'b0;
    end else if (advance1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod  <= prod_c;
        s1_round <= round_en;
      end
    end
  end

  // Stage 2 registers the saturated result and flags, and holds them while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      p_out     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (advance2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        p_out     <= p_next;
        overflow  <= ovf_next;
        underflow <= unf_next;
      end
    end
  end

  // Count delivered saturated results. The count sticks at all-ones, and a clear overrides an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (s2_valid && out_ready && (overflow || underflow) &&
                 (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fixed_sat_mult_pipe.sv
// tb_fixed_sat_mult_pipe: bench for fixed_sat_mult_pipe with default
// parameters, plus a second instance with a 2-bit saturation counter.
// A queue-based arithmetic model predicts the handshake, the results and the counters.
module tb_fixed_sat_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        round_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p_out;
  logic        overflow;
  logic        underflow;
  logic [15:0] sat_cnt;
  logic        cnt_clr;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] p_out2;
  logic        overflow2;
  logic        underflow2;
  logic [1:0]  sat_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] p;
    bit          ov;
    bit          un;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc  = 0;
  int   cnt  = 0;
  int   cnt2 = 0;

  always #5 clk = ~clk;

  fixed_sat_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .round_en(round_en), .out_valid(out_valid),
    .out_ready(out_ready), .p_out(p_out), .overflow(overflow),
    .underflow(underflow), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  fixed_sat_mult_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a_in(a_in), .b_in(b_in), .round_en(round_en), .out_valid(out_valid2),
    .out_ready(out_ready), .p_out(p_out2), .overflow(overflow2),
    .underflow(underflow2), .sat_cnt(sat_cnt2), .cnt_clr(cnt_clr)
  );

  // Compare one value and tally the result.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, optional +half LSB, floor shift by 8, clamp to 16 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit r);
    exp_t   e;
    longint pa;
    longint pb;
    longint prod;
    longint s;
    pa   = longint'($signed(a));
    pb   = longint'($signed(b));
    prod = pa * pb;
    if (r) prod = prod + 128;
    s = prod >>> 8;
    e.ov  = 1'b0;
    e.un  = 1'b0;
    e.acc = 0;
    if (s > 32767) begin
      e.p  = 16'h7FFF;
      e.ov = 1'b1;
    end else if (s < -32768) begin
      e.p  = 16'h8000;
      e.un = 1'b1;
    end else begin
      e.p = 16'(s);
    end
    return e;
  endfunction

  // Every cycle, check the DUT against the model. Then apply the transfers that the next edge will perform.
  always @(negedge clk) begin
    bit   exp_ready;
    bit   exp_valid;
    exp_t f;
    if (!rst_n) begin
      q.delete();
      cnt  = 0;
      cnt2 = 0;
    end else begin
      exp_ready = !(q.size() == 2 && !out_ready);
      exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 2);
      check("model in_ready", in_ready, exp_ready);
      check("model out_valid", out_valid, exp_valid);
      if (exp_valid && out_valid) begin
        check("model p_out", p_out, q[0].p);
        check("model overflow", overflow, q[0].ov);
        check("model underflow", underflow, q[0].un);
      end
      check("model sat_cnt", sat_cnt, cnt);
      check("model sat_cnt2", sat_cnt2, cnt2);
      if (exp_valid && out_ready) begin
        f = q.pop_front();
        if (f.ov || f.un) begin
          if (cnt < 65535) cnt++;
          if (cnt2 < 3) cnt2++;
        end
      end
      if (cnt_clr) begin
        cnt  = 0;
        cnt2 = 0;
      end
      if (in_valid && exp_ready) begin
        f = model(a_in, b_in, round_en);
        f.acc = cyc;
        q.push_back(f);
      end
    end
    cyc++;
  end

  // Present one operand pair until it is accepted. Call this just after a rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit r);
    bit acc;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    round_en = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    n_fail++;
    $display("[TB] FAIL accept timeout: got no in_ready, expected acceptance within 20 cycles");
  endtask

  // Wait for the next result, compare it with hand-computed literals, and
  // check that it appeared two cycles after acceptance.
  task automatic checkOutput(input string name, input logic [15:0] p,
                             input bit ov, input bit un);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check({name, " valid"}, out_valid, 1'b1);
    check({name, " latency"}, n, 2);
    check({name, " p_out"}, p_out, p);
    check({name, " overflow"}, overflow, ov);
    check({name, " underflow"}, underflow, un);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int          sh;
    v  = $urandom;
    sh = $urandom_range(8, 31);
    return 32'($signed(v) >>> sh);
  endfunction

  // Stop the run if it stalls, reporting the stall as a failure first.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          idx;
    int          delivered;
    logic [31:0] bp_a[8];
    logic [31:0] bp_b[8];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    round_en  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    // Values held during reset
    #7;
    check("reset out_valid", out_valid, 1'b0);
    check("reset p_out", p_out, 16'h0000);
    check("reset overflow", overflow, 1'b0);
    check("reset underflow", underflow, 1'b0);
    check("reset sat_cnt", sat_cnt, 16'h0000);
    #15;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed cases with literal expectations
    applyStimulus(32'h00000280, 32'h00000300, 1'b0);
    checkOutput("basic", 16'h0780, 1'b0, 1'b0);
    applyStimulus(32'h00001000, 32'h00001000, 1'b0);
    checkOutput("sat max", 16'h7FFF, 1'b1, 1'b0);
    applyStimulus(32'hFFFFF000, 32'h00001000, 1'b0);
    checkOutput("sat min", 16'h8000, 1'b0, 1'b1);
    applyStimulus(32'hFFFFF800, 32'h00001000, 1'b0);
    checkOutput("exact min", 16'h8000, 1'b0, 1'b0);
    applyStimulus(32'h00000001, 32'h00000080, 1'b0);
    checkOutput("pos trunc", 16'h0000, 1'b0, 1'b0);
    applyStimulus(32'h00000001, 32'h00000080, 1'b1);
    checkOutput("pos round", 16'h0001, 1'b0, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'h00000080, 1'b0);
    checkOutput("neg trunc", 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'h00000080, 1'b1);
    checkOutput("neg round", 16'h0000, 1'b0, 1'b0);

    // Five more saturations push the 2-bit counter to its ceiling
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h00001000, 32'h00001000, 1'b0);
      checkOutput("cnt sat", 16'h7FFF, 1'b1, 1'b0);
    end
    check("cnt2 ceiling", sat_cnt2, 2'd3);
    check("cnt total", sat_cnt, 16'd7);

    // A clear that coincides with a saturated transfer wins
    out_ready = 1'b0;
    applyStimulus(32'hFFFFF000, 32'h00001000, 1'b0);
    checkOutput("clr sat", 16'h8000, 1'b0, 1'b1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr sat_cnt", sat_cnt, 16'd0);
    check("clr sat_cnt2", sat_cnt2, 2'd0);

    // Randomised traffic with random backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a_in      = rnd_op();
      b_in      = rnd_op();
      round_en  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Eight back-to-back pairs under random backpressure, starting with a stalled sink
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = 32'((i + 1) * 256);
      bp_b[i] = 32'h00000100 + 32'(i * 3);
    end
    idx       = 0;
    delivered = 0;
    for (int c = 0; c < 200 && delivered < 8; c++) begin
      in_valid  = (idx < 8);
      a_in      = bp_a[idx % 8];
      b_in      = bp_b[idx % 8];
      round_en  = 1'b0;
      out_ready = (c < 4) ? 1'b0 : 1'(($urandom_range(0, 1)));
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) delivered++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp accepted", idx, 8);
    check("bp delivered", delivered, 8);

    // Reset with two saturated results in flight and a nonzero counter
    out_ready = 1'b1;
    applyStimulus(32'h00001000, 32'h00001000, 1'b0);
    checkOutput("pre-reset sat", 16'h7FFF, 1'b1, 1'b0);
    out_ready = 1'b0;
    applyStimulus(32'h00001000, 32'h00001000, 1'b0);
    applyStimulus(32'hFFFFF000, 32'h00001000, 1'b0);
    check("pre-reset full in_ready", in_ready, 1'b0);
    check("pre-reset sat_cnt nonzero", (sat_cnt != 16'd0), 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset sat_cnt", sat_cnt, 16'd0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release in_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no stale result", out_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
